pc_stack_unit: RTL



---
 rtl/pc_stack_unit_if.sv | 39 +++
 rtl/pc_stack_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - decode-side control and status bundle for pc_stack_unit
// stack_err is present only when PC_STACK_ERR_EN is defined.
interface pc_stack_unit_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             stall;
   logic             jump;
   logic [WIDTH-1:0] jump_target;
   logic             branch;
   logic [WIDTH-1:0] branch_offset;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] pc_out;
   logic [CNT_W-1:0] stack_count;
   logic             stack_empty;
   logic             stack_full;
`ifdef PC_STACK_ERR_EN
   logic             stack_err;
`endif

   modport master (
      output stall, jump, jump_target, branch, branch_offset, call, ret,
      input  pc_out, stack_count, stack_empty, stack_full
`ifdef PC_STACK_ERR_EN
      , input stack_err
`endif
   );

   modport slave (
      input  stall, jump, jump_target, branch, branch_offset, call, ret,
      output pc_out, stack_count, stack_empty, stack_full
`ifdef PC_STACK_ERR_EN
      , output stack_err
`endif
   );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - fetch-stage PC with jump/branch/call/ret and circular return stack
// Define PC_STACK_ERR_EN to add the sticky stack_err (underflow/overflow) output.
module pc_stack_unit #(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic              clock,
   input  logic              clear,
   pc_stack_unit_if.slave    bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_V  = WIDTH'(RESET_PC);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_POP,
      ACT_PUSH,
      ACT_JUMP,
      ACT_BRANCH,
      ACT_SEQ
   } action_t;

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_next;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_next;
   logic [PTR_W-1:0] top_q;
   logic [PTR_W-1:0] top_next;
   logic [PTR_W-1:0] push_ptr;
   logic [WIDTH-1:0] stack_mem [DEPTH];
   logic [WIDTH-1:0] pc_seq;
   logic [WIDTH-1:0] pc_branch;
   logic             empty;
   logic             full;
   action_t          action;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign pc_seq    = pc_q + STEP_V;
   assign pc_branch = pc_q + bus.branch_offset;
   assign push_ptr  = top_q + PTR_W'(1);

   // ret on an empty stack falls through to sequential flow and masks any call.
   always_comb begin
      action = ACT_SEQ;
      if (bus.stall)
         action = ACT_HOLD;
      else if (bus.ret && !empty)
         action = ACT_POP;
      else if (bus.ret)
         action = ACT_SEQ;
      else if (bus.call)
         action = ACT_PUSH;
      else if (bus.jump)
         action = ACT_JUMP;
      else if (bus.branch)
         action = ACT_BRANCH;
   end

   always_comb begin
      pc_next    = pc_q;
      count_next = count_q;
      top_next   = top_q;
      unique case (action)
         ACT_HOLD: ;
         ACT_POP: begin
            pc_next    = stack_mem[top_q];
            count_next = count_q - CNT_W'(1);
            top_next   = top_q - PTR_W'(1);
         end
         ACT_PUSH: begin
            // A full stack keeps its count; the push overwrites the oldest slot.
            pc_next    = bus.jump_target;
            count_next = full ? count_q : count_q + CNT_W'(1);
            top_next   = push_ptr;
         end
         ACT_JUMP:   pc_next = bus.jump_target;
         ACT_BRANCH: pc_next = pc_branch;
         ACT_SEQ:    pc_next = pc_seq;
         default:    pc_next = pc_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         pc_q    <= RESET_V;
         count_q <= '0;
         top_q   <= '0;
      end else begin
         pc_q    <= pc_next;
         count_q <= count_next;
         top_q   <= top_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!clear && action == ACT_PUSH)
         stack_mem[push_ptr] <= pc_seq;
   end

   assign bus.pc_out      = pc_q;
   assign bus.stack_count = count_q;
   assign bus.stack_empty = empty;
   assign bus.stack_full  = full;

`ifdef PC_STACK_ERR_EN
   logic err_q;
   logic underflow;
   logic overflow;

   assign underflow = !bus.stall && bus.ret && empty;
   assign overflow  = !bus.stall && !bus.ret && bus.call && full;

   always_ff @(posedge clock) begin
      if (clear)
         err_q <= 1'b0;
      else if (underflow || overflow)
         err_q <= 1'b1;
   end

   assign bus.stack_err = err_q;
`else
`endif
endmodule
